store_buffer_fwd: RTL and testbench

- Parametrised store buffer between the LSQ/execute stage and the D-cache write port of the out-of-order core.
- Stores enter speculatively, in program order, at address generation.
- The ROB commits each store, in order, at retirement. Committed entries drain to memory one at a time, oldest first.
- Younger loads get byte-granular forwarding from all valid entries.
- A pipeline flush discards every uncommitted entry in one cycle.

---
 rtl/store_buffer_fwd.sv | 241 ++++++++++++++++++++++++
 tb/tb_store_buffer_fwd.sv | 507 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer_fwd.sv
// store_buffer_fwd
// Speculative store buffer sitting between execute and the D-cache write port.
// Stores allocate in program order, the ROB commits them in order, committed
// entries drain one at a time (single outstanding write), and younger loads
// receive byte-granular forwarding from every valid entry.

module store_buffer_fwd #(
    parameter int SB_DEPTH = 8,
    parameter int TAG_W    = 5,
    parameter int ADDR_W   = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      alloc_valid,
    output logic                      alloc_ready,
    input  logic [TAG_W-1:0]          alloc_rob_tag,
    input  logic [ADDR_W-1:0]         alloc_addr,
    input  logic [31:0]               alloc_wdata,
    input  logic [3:0]                alloc_wmask,
    input  logic                      commit_valid,
    input  logic [TAG_W-1:0]          commit_rob_tag,
    output logic                      commit_err,
    input  logic                      flush,
    output logic                      dmem_req_valid,
    input  logic                      dmem_req_ready,
    output logic [ADDR_W-1:0]         dmem_addr,
    output logic [31:0]               dmem_wdata,
    output logic [3:0]                dmem_wmask,
    input  logic                      dmem_resp,
    input  logic [ADDR_W-1:0]         ld_addr,
    input  logic [3:0]                ld_rmask,
    output logic [3:0]                fwd_mask,
    output logic [31:0]               fwd_data,
    output logic [$clog2(SB_DEPTH):0] count,
    output logic                      empty,
    output logic                      full
);

    localparam int PW = $clog2(SB_DEPTH);
    localparam int CW = PW + 1;
    localparam int WA = ADDR_W - 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } drain_state_e;

    // Entry storage; only the word address is kept, byte lanes come from the mask.
    logic [TAG_W-1:0] tag_r  [SB_DEPTH];
    logic [WA-1:0]    addr_r [SB_DEPTH];
    logic [31:0]      data_r [SB_DEPTH];
    logic [3:0]       mask_r [SB_DEPTH];

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [CW-1:0] head_r;
    logic [CW-1:0] cptr_r;
    logic [CW-1:0] tail_r;
    logic [CW-1:0] head_nxt_s;
    logic [CW-1:0] cptr_nxt_s;
    logic [CW-1:0] tail_nxt_s;
    logic [CW-1:0] count_nxt_s;
    logic [CW-1:0] used_s;

    logic          alloc_fire_s;
    logic          commit_ok_s;
    logic          pop_s;
    logic          wr_en_s;
    logic          full_nxt_s;

    logic [CW-1:0] count_r;
    logic          empty_r;
    logic          full_r;
    logic          alloc_ready_r;
    logic          commit_err_r;

    drain_state_e      state_r;
    logic              dmem_req_valid_r;
    logic [ADDR_W-1:0] dmem_addr_r;
    logic [31:0]       dmem_wdata_r;
    logic [3:0]        dmem_wmask_r;

    logic [3:0]  fwd_mask_s;
    logic [31:0] fwd_data_s;
    logic        unused_s;

    // Byte-offset address bits never participate in matching or draining.
    assign unused_s = ^{alloc_addr[1:0], ld_addr[1:0]};

    assign used_s = tail_r - head_r;

    // Next-state pointer arithmetic: commit resolves before flush truncates the tail.
    always_comb begin
        alloc_fire_s = alloc_valid & alloc_ready_r;
        if (commit_valid && (cptr_r != tail_r)) begin
            commit_ok_s = (tag_r[cptr_r[PW-1:0]] == commit_rob_tag);
        end else begin
            commit_ok_s = 1'b0;
        end
        pop_s      = (state_r == ST_WAIT) && dmem_resp;
        head_nxt_s = head_r + CW'(pop_s);
        cptr_nxt_s = cptr_r + CW'(commit_ok_s);
        if (flush) begin
            tail_nxt_s = cptr_nxt_s;
        end else begin
            tail_nxt_s = tail_r + CW'(alloc_fire_s);
        end
        wr_en_s     = alloc_fire_s & ~flush;
        count_nxt_s = tail_nxt_s - head_nxt_s;
        full_nxt_s  = (tail_nxt_s[PW-1:0] == head_nxt_s[PW-1:0]) &&
                      (tail_nxt_s[PW] != head_nxt_s[PW]);
    end

    // Pointer and status registers; status is precomputed from next-state pointers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_r        <= {CW{1'b0}};
            cptr_r        <= {CW{1'b0}};
            tail_r        <= {CW{1'b0}};
            count_r       <= {CW{1'b0}};
            empty_r       <= 1'b1;
            full_r        <= 1'b0;
            alloc_ready_r <= 1'b1;
            commit_err_r  <= 1'b0;
        end else begin
            head_r        <= head_nxt_s;
            cptr_r        <= cptr_nxt_s;
            tail_r        <= tail_nxt_s;
            count_r       <= count_nxt_s;
            empty_r       <= (count_nxt_s == {CW{1'b0}});
            full_r        <= full_nxt_s;
            alloc_ready_r <= ~full_nxt_s;
            commit_err_r  <= commit_valid & ~commit_ok_s;
        end
    end

    // Entry write at the tail; contents are don't-care until allocated.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            tag_r[tail_r[PW-1:0]]  <= alloc_rob_tag;
            addr_r[tail_r[PW-1:0]] <= alloc_addr[ADDR_W-1:2];
            data_r[tail_r[PW-1:0]] <= alloc_wdata;
            mask_r[tail_r[PW-1:0]] <= alloc_wmask;
        end
    end

    // Drain FSM: one outstanding write; request fields are latched and held until accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r          <= ST_IDLE;
            dmem_req_valid_r <= 1'b0;
            dmem_addr_r      <= {ADDR_W{1'b0}};
            dmem_wdata_r     <= 32'h0000_0000;
            dmem_wmask_r     <= 4'b0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (head_r != cptr_r) begin
                        state_r          <= ST_REQ;
                        dmem_req_valid_r <= 1'b1;
                        dmem_addr_r      <= {addr_r[head_r[PW-1:0]], 2'b00};
                        dmem_wdata_r     <= data_r[head_r[PW-1:0]];
                        dmem_wmask_r     <= mask_r[head_r[PW-1:0]];
                    end else begin
                        state_r          <= ST_IDLE;
                        dmem_req_valid_r <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (dmem_req_ready) begin
                        state_r          <= ST_WAIT;
                        dmem_req_valid_r <= 1'b0;
                    end else begin
                        state_r          <= ST_REQ;
                        dmem_req_valid_r <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (dmem_resp) begin
                        if (head_nxt_s != cptr_r) begin
                            state_r          <= ST_REQ;
                            dmem_req_valid_r <= 1'b1;
                            dmem_addr_r      <= {addr_r[head_nxt_s[PW-1:0]], 2'b00};
                            dmem_wdata_r     <= data_r[head_nxt_s[PW-1:0]];
                            dmem_wmask_r     <= mask_r[head_nxt_s[PW-1:0]];
                        end else begin
                            state_r          <= ST_IDLE;
                            dmem_req_valid_r <= 1'b0;
                            dmem_addr_r      <= {ADDR_W{1'b0}};
                            dmem_wdata_r     <= 32'h0000_0000;
                            dmem_wmask_r     <= 4'b0000;
                        end
                    end else begin
                        state_r          <= ST_WAIT;
                        dmem_req_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r          <= ST_IDLE;
                    dmem_req_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Forwarding scan oldest to youngest so younger matching bytes overwrite older ones.
    always_comb begin : fwd_scan
        logic [PW-1:0] idx_v;
        logic          hit_v;
        fwd_mask_s = 4'b0000;
        fwd_data_s = 32'h0000_0000;
        idx_v      = {PW{1'b0}};
        hit_v      = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            idx_v = head_r[PW-1:0] + PW'(i);
            hit_v = (CW'(i) < used_s) && (addr_r[idx_v] == ld_addr[ADDR_W-1:2]);
            for (int b = 0; b < 4; b++) begin
                if (hit_v && mask_r[idx_v][b] && ld_rmask[b]) begin
                    fwd_mask_s[b]       = 1'b1;
                    fwd_data_s[8*b +: 8] = data_r[idx_v][8*b +: 8];
                end else begin
                    fwd_mask_s[b]       = fwd_mask_s[b];
                    fwd_data_s[8*b +: 8] = fwd_data_s[8*b +: 8];
                end
            end
        end
    end

    assign alloc_ready    = alloc_ready_r;
    assign commit_err     = commit_err_r;
    assign dmem_req_valid = dmem_req_valid_r;
    assign dmem_addr      = dmem_addr_r;
    assign dmem_wdata     = dmem_wdata_r;
    assign dmem_wmask     = dmem_wmask_r;
    assign fwd_mask       = fwd_mask_s;
    assign fwd_data       = fwd_data_s;
    assign count          = count_r;
    assign empty          = empty_r;
    assign full           = full_r;

endmodule

// File: tb/tb_store_buffer_fwd.sv
// Testbench for store_buffer_fwd: directed scenarios plus a randomized run,
// checked against a queue-based model of the store buffer.

module tb_store_buffer_fwd;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        alloc_valid;
    logic        alloc_ready;
    logic [4:0]  alloc_rob_tag;
    logic [31:0] alloc_addr;
    logic [31:0] alloc_wdata;
    logic [3:0]  alloc_wmask;
    logic        commit_valid;
    logic [4:0]  commit_rob_tag;
    logic        commit_err;
    logic        flush;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wmask;
    logic        dmem_resp;
    logic [31:0] ld_addr;
    logic [3:0]  ld_rmask;
    logic [3:0]  fwd_mask;
    logic [31:0] fwd_data;
    logic [3:0]  count;
    logic        empty;
    logic        full;

    store_buffer_fwd #(.SB_DEPTH(8), .TAG_W(5), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_rob_tag(alloc_rob_tag), .alloc_addr(alloc_addr),
        .alloc_wdata(alloc_wdata), .alloc_wmask(alloc_wmask),
        .commit_valid(commit_valid), .commit_rob_tag(commit_rob_tag),
        .commit_err(commit_err), .flush(flush),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wmask(dmem_wmask),
        .dmem_resp(dmem_resp), .ld_addr(ld_addr), .ld_rmask(ld_rmask),
        .fwd_mask(fwd_mask), .fwd_data(fwd_data),
        .count(count), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  tag;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } ent_t;

    // Model: queue of entries oldest first; the first mcomm are committed.
    ent_t mq[$];
    int   mcomm;
    bit   outstanding;
    bit   exp_err;
    ent_t exp_wr[$];
    ent_t got_wr[$];

    int   ready_pct = 100;
    int   resp_pct  = 100;
    int   unstable_cnt;
    bit   stall_prev;
    logic [31:0] prev_a, prev_d;
    logic [3:0]  prev_m;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void model_fwd(input logic [31:0] la, input logic [3:0] rm,
                                      output logic [3:0] m, output logic [31:0] d);
        m = 4'b0000;
        d = 32'h0;
        foreach (mq[i]) begin
            if (mq[i].addr[31:2] == la[31:2]) begin
                for (int b = 0; b < 4; b++) begin
                    if (mq[i].mask[b] && rm[b]) begin
                        m[b] = 1'b1;
                        d[8*b +: 8] = mq[i].data[8*b +: 8];
                    end
                end
            end
        end
    endfunction

    task automatic idle_inputs();
        alloc_valid  = 1'b0;
        commit_valid = 1'b0;
        flush        = 1'b0;
    endtask

    // One clock: acts as the D-cache, records observed writes, advances the model.
    task automatic step();
        bit   hs, pop, acc, cok;
        ent_t e;
        dmem_req_ready = ($urandom_range(0, 99) < ready_pct);
        dmem_resp      = outstanding && ($urandom_range(0, 99) < resp_pct);
        #1;
        hs = dmem_req_valid && dmem_req_ready;
        if (stall_prev && (!dmem_req_valid || dmem_addr !== prev_a ||
                           dmem_wdata !== prev_d || dmem_wmask !== prev_m))
            unstable_cnt++;
        stall_prev = dmem_req_valid && !dmem_req_ready;
        prev_a = dmem_addr; prev_d = dmem_wdata; prev_m = dmem_wmask;
        if (hs) begin
            e.tag = 5'd0; e.addr = dmem_addr; e.data = dmem_wdata; e.mask = dmem_wmask;
            got_wr.push_back(e);
        end
        acc = alloc_valid && (mq.size() < DEPTH);
        cok = commit_valid && (mcomm < mq.size()) && (mq[mcomm].tag == commit_rob_tag);
        pop = dmem_resp && outstanding;
        @(posedge clk);
        if (pop) begin
            e = mq[0];
            e.tag = 5'd0;
            e.addr = {mq[0].addr[31:2], 2'b00};
            exp_wr.push_back(e);
            void'(mq.pop_front());
            mcomm--;
            outstanding = 1'b0;
        end
        if (hs) outstanding = 1'b1;
        if (cok) mcomm++;
        if (flush) begin
            while (mq.size() > mcomm) void'(mq.pop_back());
        end else if (acc) begin
            e.tag = alloc_rob_tag; e.addr = alloc_addr; e.data = alloc_wdata; e.mask = alloc_wmask;
            mq.push_back(e);
        end
        exp_err = commit_valid && !cok;
        @(negedge clk);
    endtask

    task automatic drain_all(output bit timed_out);
        for (int c = 0; c < 200 && (mcomm > 0 || outstanding); c++) step();
        timed_out = (mcomm > 0) || outstanding;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        dmem_req_ready = 1'b0; dmem_resp = 1'b0;
        ld_addr = 32'h0; ld_rmask = 4'hF;
        alloc_rob_tag = 5'd0; alloc_addr = 32'h0; alloc_wdata = 32'h0; alloc_wmask = 4'h0;
        commit_rob_tag = 5'd0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({alloc_ready, commit_err, dmem_req_valid, empty, full} !== 5'b10010) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 10010",
                     {alloc_ready, commit_err, dmem_req_valid, empty, full});
        end
        n_checks++;
        if ({dmem_addr, dmem_wdata, dmem_wmask} !== 68'h0) begin
            n_fail++;
            $display("FAIL reset_dmem: got %h/%h/%h expected 0", dmem_addr, dmem_wdata, dmem_wmask);
        end
        n_checks++;
        if ({fwd_mask, fwd_data, count} !== 40'h0) begin
            n_fail++;
            $display("FAIL reset_fwd_count: got %h/%h/%0d expected 0", fwd_mask, fwd_data, count);
        end
        mq.delete(); mcomm = 0; outstanding = 1'b0; stall_prev = 1'b0;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fill();
        ready_pct = 100; resp_pct = 100;
        for (int i = 0; i < 9; i++) begin
            alloc_valid = 1'b1;
            alloc_rob_tag = 5'(i + 1);
            alloc_addr = 32'h100 + 32'(4 * i);
            alloc_wdata = $urandom;
            alloc_wmask = 4'hF;
            step();
            n_checks++;
            if (count !== 4'((i < 8) ? i + 1 : 8)) begin
                n_fail++;
                $display("FAIL fill_count[%0d]: got %0d expected %0d", i, count, (i < 8) ? i + 1 : 8);
            end
            n_checks++;
            if (dmem_req_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL fill_no_drain[%0d]: got %b expected 0", i, dmem_req_valid);
            end
        end
        idle_inputs();
        n_checks++;
        if ({full, alloc_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL fill_full: got full/ready %b expected 10", {full, alloc_ready});
        end
    endtask

    task automatic test_commit_drain();
        bit to;
        got_wr.delete(); exp_wr.delete();
        for (int t = 1; t <= 2; t++) begin
            commit_valid = 1'b1;
            commit_rob_tag = 5'(t);
            step();
            n_checks++;
            if (commit_err !== 1'b0) begin
                n_fail++;
                $display("FAIL commit_ok[%0d]: got err %b expected 0", t, commit_err);
            end
        end
        idle_inputs();
        drain_all(to);
        n_checks++;
        if (to) begin
            n_fail++;
            $display("FAIL drain_timeout: got pending %0d expected 0", mcomm);
        end
        n_checks++;
        if (got_wr.size() != 2 || got_wr[0].addr !== 32'h100 || got_wr[1].addr !== 32'h104) begin
            n_fail++;
            $display("FAIL drain_order: got %0d writes first %h expected 2 writes 100,104",
                     got_wr.size(), (got_wr.size() > 0) ? got_wr[0].addr : 32'h0);
        end
        foreach (exp_wr[i]) begin
            n_checks++;
            if (i >= got_wr.size() || got_wr[i].data !== exp_wr[i].data || got_wr[i].mask !== exp_wr[i].mask) begin
                n_fail++;
                $display("FAIL drain_data[%0d]: expected %h/%h", i, exp_wr[i].data, exp_wr[i].mask);
            end
        end
        n_checks++;
        if (count !== 4'd6) begin
            n_fail++;
            $display("FAIL drain_count: got %0d expected 6", count);
        end
        flush = 1'b1; step(); flush = 1'b0;
        n_checks++;
        if (count !== 4'd0) begin
            n_fail++;
            $display("FAIL flush_all: got %0d expected 0", count);
        end
    endtask

    task automatic test_forward();
        alloc_valid = 1'b1; alloc_rob_tag = 5'd10; alloc_addr = 32'h200;
        alloc_wdata = 32'h0000_00AA; alloc_wmask = 4'b0001;
        step();
        alloc_rob_tag = 5'd11; alloc_wdata = 32'hBBBB_0000; alloc_wmask = 4'b1100;
        step();
        idle_inputs();
        ld_addr = 32'h200; ld_rmask = 4'b1111;
        #1;
        n_checks++;
        if (fwd_mask !== 4'b1101 || fwd_data !== 32'hBBBB_00AA) begin
            n_fail++;
            $display("FAIL fwd_merge: got %b/%h expected 1101/bbbb00aa", fwd_mask, fwd_data);
        end
        ld_addr = 32'h202; ld_rmask = 4'b0010;
        #1;
        n_checks++;
        if (fwd_mask !== 4'b0000 || fwd_data !== 32'h0) begin
            n_fail++;
            $display("FAIL fwd_nolane: got %b/%h expected 0000/0", fwd_mask, fwd_data);
        end
        ld_addr = 32'h204; ld_rmask = 4'b1111;
        #1;
        n_checks++;
        if (fwd_mask !== 4'b0000) begin
            n_fail++;
            $display("FAIL fwd_otherword: got %b expected 0000", fwd_mask);
        end
        flush = 1'b1; step(); flush = 1'b0;
    endtask

    task automatic test_flush_commit();
        bit to;
        logic [3:0] em;
        logic [31:0] ed;
        got_wr.delete(); exp_wr.delete();
        for (int i = 0; i < 4; i++) begin
            alloc_valid = 1'b1; alloc_rob_tag = 5'(3 + i);
            alloc_addr = 32'h300 + 32'(4 * i); alloc_wdata = $urandom; alloc_wmask = 4'hF;
            step();
        end
        alloc_valid = 1'b1; alloc_rob_tag = 5'd20; alloc_addr = 32'h304;
        commit_valid = 1'b1; commit_rob_tag = 5'd3; flush = 1'b1;
        step();
        idle_inputs();
        n_checks++;
        if (count !== 4'd1) begin
            n_fail++;
            $display("FAIL flush_commit_count: got %0d expected 1", count);
        end
        alloc_valid = 1'b1; alloc_rob_tag = 5'd7; alloc_addr = 32'h400;
        alloc_wdata = 32'h1234_5678; alloc_wmask = 4'b0110;
        step();
        alloc_valid = 1'b0;
        n_checks++;
        if (count !== 4'd2) begin
            n_fail++;
            $display("FAIL flush_realloc_count: got %0d expected 2", count);
        end
        ld_addr = 32'h304; ld_rmask = 4'hF;
        #1;
        n_checks++;
        if (fwd_mask !== 4'b0000) begin
            n_fail++;
            $display("FAIL flush_squashed_fwd: got %b expected 0000", fwd_mask);
        end
        ld_addr = 32'h400;
        #1;
        model_fwd(ld_addr, ld_rmask, em, ed);
        n_checks++;
        if (fwd_mask !== em || fwd_data !== ed) begin
            n_fail++;
            $display("FAIL flush_realloc_fwd: got %b/%h expected %b/%h", fwd_mask, fwd_data, em, ed);
        end
        drain_all(to);
        n_checks++;
        if (to || got_wr.size() != 1 || got_wr[0].addr !== 32'h300) begin
            n_fail++;
            $display("FAIL flush_drain: got %0d writes expected one write to 300", got_wr.size());
        end
        flush = 1'b1; step(); flush = 1'b0;
    endtask

    task automatic test_commit_err();
        bit to;
        for (int i = 0; i < 2; i++) begin
            alloc_valid = 1'b1; alloc_rob_tag = 5'(4 + i);
            alloc_addr = 32'h500 + 32'(4 * i); alloc_wdata = $urandom; alloc_wmask = 4'hF;
            step();
        end
        alloc_valid = 1'b0;
        commit_valid = 1'b1; commit_rob_tag = 5'd9;
        step();
        commit_valid = 1'b0;
        n_checks++;
        if (commit_err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_mismatch: got %b expected 1", commit_err);
        end
        step();
        n_checks++;
        if (commit_err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_pulse_width: got %b expected 0", commit_err);
        end
        for (int t = 4; t <= 6; t++) begin
            commit_valid = 1'b1; commit_rob_tag = 5'(t);
            step();
            n_checks++;
            if (commit_err !== ((t == 6) ? 1'b1 : 1'b0)) begin
                n_fail++;
                $display("FAIL err_commit[%0d]: got %b expected %b", t, commit_err, t == 6);
            end
        end
        idle_inputs();
        drain_all(to);
        flush = 1'b1; step(); flush = 1'b0;
    endtask

    task automatic test_stall_wrap();
        bit to;
        got_wr.delete(); exp_wr.delete();
        unstable_cnt = 0;
        for (int r = 0; r < 3; r++) begin
            ready_pct = 0;
            for (int k = 0; k < 5; k++) begin
                alloc_valid = 1'b1; alloc_rob_tag = 5'(r * 5 + k);
                alloc_addr = 32'h700 + 32'(4 * (r * 5 + k)); alloc_wdata = $urandom;
                alloc_wmask = 4'($urandom_range(1, 15));
                step();
            end
            alloc_valid = 1'b0;
            for (int k = 0; k < 5; k++) begin
                commit_valid = 1'b1; commit_rob_tag = mq[mcomm].tag;
                step();
            end
            commit_valid = 1'b0;
            for (int k = 0; k < 5; k++) begin
                step();
                n_checks++;
                if (dmem_req_valid !== 1'b1 || dmem_addr !== {mq[0].addr[31:2], 2'b00} ||
                    dmem_wdata !== mq[0].data || dmem_wmask !== mq[0].mask) begin
                    n_fail++;
                    $display("FAIL stall_hold[%0d.%0d]: got %b %h %h %h expected 1 %h %h %h", r, k,
                             dmem_req_valid, dmem_addr, dmem_wdata, dmem_wmask,
                             mq[0].addr, mq[0].data, mq[0].mask);
                end
            end
            ready_pct = 100;
            drain_all(to);
            n_checks++;
            if (to || count !== 4'd0) begin
                n_fail++;
                $display("FAIL stall_drain[%0d]: got count %0d expected 0", r, count);
            end
        end
        n_checks++;
        if (unstable_cnt != 0) begin
            n_fail++;
            $display("FAIL stall_stable: got %0d changes expected 0", unstable_cnt);
        end
        n_checks++;
        if (got_wr.size() != 15 || exp_wr.size() != 15) begin
            n_fail++;
            $display("FAIL wrap_count: got %0d writes expected 15", got_wr.size());
        end
        foreach (exp_wr[i]) begin
            n_checks++;
            if (i >= got_wr.size() || got_wr[i].addr !== exp_wr[i].addr ||
                got_wr[i].data !== exp_wr[i].data || got_wr[i].mask !== exp_wr[i].mask) begin
                n_fail++;
                $display("FAIL wrap_write[%0d]: expected %h %h %h", i,
                         exp_wr[i].addr, exp_wr[i].data, exp_wr[i].mask);
            end
        end
    endtask

    task automatic test_random();
        bit to;
        logic [3:0]  em;
        logic [31:0] ed;
        logic [4:0]  next_tag = 5'd0;
        got_wr.delete(); exp_wr.delete();
        unstable_cnt = 0;
        ready_pct = 60; resp_pct = 50;
        for (int c = 0; c < 600; c++) begin
            alloc_valid = ($urandom_range(0, 99) < 60);
            alloc_rob_tag = next_tag;
            if (alloc_valid) next_tag = next_tag + 5'd1;
            alloc_addr = 32'h600 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3));
            alloc_wdata = $urandom;
            alloc_wmask = 4'($urandom_range(0, 15));
            commit_valid = ($urandom_range(0, 99) < 40);
            if (mcomm < mq.size() && $urandom_range(0, 99) < 85)
                commit_rob_tag = mq[mcomm].tag;
            else
                commit_rob_tag = 5'($urandom_range(0, 31));
            flush = ($urandom_range(0, 99) < 3);
            ld_addr = 32'h600 + 32'($urandom_range(0, 4) * 4) + 32'($urandom_range(0, 3));
            ld_rmask = 4'($urandom_range(0, 15));
            #1;
            model_fwd(ld_addr, ld_rmask, em, ed);
            n_checks++;
            if (fwd_mask !== em || fwd_data !== ed) begin
                n_fail++;
                $display("FAIL rnd_fwd[%0d]: got %b/%h expected %b/%h", c, fwd_mask, fwd_data, em, ed);
            end
            step();
            n_checks++;
            if (count !== 4'(mq.size()) || empty !== (mq.size() == 0) ||
                full !== (mq.size() == DEPTH) || alloc_ready !== (mq.size() < DEPTH)) begin
                n_fail++;
                $display("FAIL rnd_status[%0d]: got cnt %0d e%b f%b r%b expected cnt %0d",
                         c, count, empty, full, alloc_ready, mq.size());
            end
            n_checks++;
            if (commit_err !== exp_err) begin
                n_fail++;
                $display("FAIL rnd_commit_err[%0d]: got %b expected %b", c, commit_err, exp_err);
            end
        end
        idle_inputs();
        ready_pct = 100; resp_pct = 100;
        drain_all(to);
        n_checks++;
        if (to || got_wr.size() != exp_wr.size() || unstable_cnt != 0) begin
            n_fail++;
            $display("FAIL rnd_drain: got %0d writes, %0d unstable; expected %0d writes, 0 unstable",
                     got_wr.size(), unstable_cnt, exp_wr.size());
        end
        foreach (exp_wr[i]) begin
            n_checks++;
            if (i >= got_wr.size() || got_wr[i].addr !== exp_wr[i].addr ||
                got_wr[i].data !== exp_wr[i].data || got_wr[i].mask !== exp_wr[i].mask) begin
                n_fail++;
                $display("FAIL rnd_write[%0d]: expected %h %h %h", i,
                         exp_wr[i].addr, exp_wr[i].data, exp_wr[i].mask);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill();
        test_commit_drain();
        test_forward();
        test_flush_commit();
        test_commit_err();
        test_stall_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
